fifo_umbrales: RTL
==================

Name: fifo_umbrales

Overview:
Synchronous FIFO with run-time programmable almost-empty/almost-full thresholds. It is instantiated once per queue (Main, VC0, VC1, D0, D1) directly downstream of the control state machine. It latches the low/high thresholds that the state machine drives during its INIT state. It feeds back its empty and error flags, which the state machine collects into its 5-bit empties and errors buses.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH = 16 entries
UMBRAL_W, 5, threshold width; fixed by the control state machine interface

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
cfg_load  in  1  when 1, capture umbral_bajo/umbral_alto at posedge
umbral_bajo  in  UMBRAL_W  almost-empty threshold (entries)
umbral_alto  in  UMBRAL_W  almost-full threshold (entries)
push  in  1  write request
data_in  in  DATA_WIDTH  write data
pop  in  1  read request
data_out  out  DATA_WIDTH  registered read data
data_valid  out  1  data_out holds a newly popped word this cycle
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= threshold_bajo_q
almost_full  out  1  count >= threshold_alto_q
error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset asserted (reset==0, asynchronous):
  - wr_ptr, rd_ptr and count = 0; data_out = 0; data_valid = 0; error = 0.
  - threshold_bajo_q = UMBRAL_BAJO_DEF (1); threshold_alto_q = UMBRAL_ALTO_DEF (DEPTH-1 = 15).
  - Outputs therefore read empty=1, almost_empty=1, full=0, almost_full=0.
  - Storage array is not reset.
- Threshold capture: cfg_load=1 at posedge loads both thresholds; the new values affect the flags from the next cycle. cfg_load is independent of push/pop, and all may occur in the same cycle.
- Push accepted iff push=1 and (full=0, or pop is also accepted that cycle). The word is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop accepted iff pop=1 and empty=0. data_out <= mem[rd_ptr] at that posedge, so the data is visible 1 cycle after the pop request. rd_ptr increments modulo DEPTH. data_valid=1 in that following cycle, otherwise 0. data_out holds its last value when no pop is accepted.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags: combinational from registered count and thresholds, so they update in the cycle after the push/pop.
- Threshold comparisons are unsigned, with count zero-extended to UMBRAL_W:
  - umbral_alto > DEPTH means almost_full never asserts.
  - umbral_alto = 0 means almost_full is always 1.
- Overflow: push=1 while full=1 and no accepted pop. Data is dropped, pointers and count are unchanged, and error <= 1.
- Underflow: pop=1 while empty=1. Nothing is read, data_valid=0, and error <= 1.
- Empty with push=1 and pop=1 in the same cycle: the push is accepted, the pop is rejected, and this counts as underflow (no bypass path).
- Full with push=1 and pop=1 in the same cycle: both are accepted, count stays DEPTH, no error.
- error is sticky and is cleared only by reset; the control state machine relies on this to remain in ERROR.
- Reset mid-operation: all contents are discarded, the FIFO returns to empty, and thresholds return to their defaults.

Decomposition:
- Shared package fifo_pkg holds:
  - UMBRAL_W
  - UMBRAL_BAJO_DEF, UMBRAL_ALTO_DEF
  - default DATA_WIDTH and ADDR_WIDTH
  - the queue index constants MF=0, VC0=1, VC1=2, D0=3, D1=4, which map each instance to its bit of the empties/errors buses
- One sub-module, memoria_fifo: DEPTH x DATA_WIDTH dual-port array with synchronous write (we, wr_addr) and synchronous registered read (re, rd_addr). No reset on the array.
- Pointer, count, flag and error logic stay in fifo_umbrales.

Test Plan:
- Reset then idle: reset low for 2 cycles, then high -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, error=0, data_out=0.
- Threshold load and flags: cfg_load with umbral_bajo=2 and umbral_alto=5, then push 0x01..0x05 on consecutive cycles.
  - almost_empty deasserts when count reaches 3.
  - almost_full asserts when count reaches 5.
- Ordering and latency: after the previous scenario, pop 5 consecutive cycles -> data_out = 0x01..0x05, each 1 cycle after its pop, with data_valid=1 for 5 cycles. Then empty=1 and count=0.
- Wrap-around: push 16 words, pop 10, push 10, pop 16 -> all words come out in order across the pointer wrap; full=1 exactly when count=16; error=0 throughout.
- Overflow vs simultaneous:
  - With the FIFO full, push and pop together -> count stays 16, error=0.
  - Then push alone -> word dropped, count stays 16, error=1 and stays 1 for the next 10 cycles.
- Underflow and async reset:
  - With the FIFO empty, push=1 and pop=1 together -> count=1, data_valid=0, error=1.
  - Then drop reset low between clock edges -> error=0 and count=0 immediately, before the next edge; thresholds read back as 1/15 through the flags.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the per-queue threshold FIFOs.
// Defaults, threshold width and the queue-to-bus-bit mapping live here.
package fifo_pkg;

    localparam int UMBRAL_W       = 5;
    localparam int DATA_WIDTH_DEF = 6;
    localparam int ADDR_WIDTH_DEF = 4;

    localparam logic [UMBRAL_W-1:0] UMBRAL_BAJO_DEF = 5'd1;
    localparam logic [UMBRAL_W-1:0] UMBRAL_ALTO_DEF = 5'd15;

    // Bit position of each queue inside the empties/errors buses
    localparam int MF  = 0;
    localparam int VC0 = 1;
    localparam int VC1 = 2;
    localparam int D0  = 3;
    localparam int D1  = 4;

endpackage

// File: rtl/memoria_fifo.sv
// Dual-port storage: synchronous write, registered synchronous read.
// Only the read register is reset; the array itself keeps its contents.
module memoria_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-before-write when both ports hit the same slot (full push+pop)
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else if (i_re) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= r_rd_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with run-time programmable almost-empty/almost-full
// thresholds and a sticky overflow/underflow error flag.
module fifo_umbrales
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cfg_load,
    input  logic [UMBRAL_W-1:0]   i_umbral_bajo,
    input  logic [UMBRAL_W-1:0]   i_umbral_alto,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_valid,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic                  o_error
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [UMBRAL_W-1:0]   r_umbral_bajo;
    logic [UMBRAL_W-1:0]   r_umbral_alto;
    logic                  r_error;
    logic                  r_data_valid;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [UMBRAL_W-1:0]   w_count_ext;

    assign w_empty     = (r_count == {(ADDR_WIDTH+1){1'b0}});
    assign w_full      = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    // No bypass: a pop on an empty FIFO is rejected even if a push arrives
    assign w_pop_ok    = i_pop & ~w_empty;
    assign w_push_ok   = i_push & (~w_full | w_pop_ok);
    assign w_overflow  = i_push & w_full & ~w_pop_ok;
    assign w_underflow = i_pop & w_empty;
    assign w_count_ext = UMBRAL_W'(r_count);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= {ADDR_WIDTH{1'b0}};
            r_rd_ptr <= {ADDR_WIDTH{1'b0}};
            r_count  <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Thresholds, sticky error and the read-valid strobe
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_umbral_bajo <= UMBRAL_BAJO_DEF;
            r_umbral_alto <= UMBRAL_ALTO_DEF;
            r_error       <= 1'b0;
            r_data_valid  <= 1'b0;
        end else begin
            if (i_cfg_load) begin
                r_umbral_bajo <= i_umbral_bajo;
                r_umbral_alto <= i_umbral_alto;
            end
            r_error      <= r_error | w_overflow | w_underflow;
            r_data_valid <= w_pop_ok;
        end
    end

    memoria_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_memoria (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_we       (w_push_ok),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (i_data_in),
        .i_re       (w_pop_ok),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (o_data_out)
    );

    assign o_data_valid   = r_data_valid;
    assign o_count        = r_count;
    assign o_empty        = w_empty;
    assign o_full         = w_full;
    assign o_almost_empty = (w_count_ext <= r_umbral_bajo);
    assign o_almost_full  = (w_count_ext >= r_umbral_alto);
    assign o_error        = r_error;

endmodule
